// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath width, NOP encoding and the
// fetch-to-decode queue entry layout.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/pipe_ifq_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, flush and occupancy.
interface pipe_ifq_if import pipe_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = XLEN
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_pc4;
    logic [WIDTH-1:0] in_inst;
    logic             in_ready;
    logic             f_flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc4;
    logic [WIDTH-1:0] out_inst;
    logic             out_ready;
    logic             d_flush;
    logic [CW-1:0]    count;

    // Pipeline side that feeds and drains the queue
    modport master (
        output in_valid, in_pc4, in_inst, f_flush, out_ready,
        input  in_ready, out_valid, out_pc4, out_inst, d_flush, count
    );

    // The queue itself
    modport slave (
        input  in_valid, in_pc4, in_inst, f_flush, out_ready,
        output in_ready, out_valid, out_pc4, out_inst, d_flush, count
    );

endinterface

// File: rtl/pipe_ifq_regfile.sv
// Queue storage: DEPTH x DW array, synchronous write, asynchronous read.
module ifq_regfile #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Contents need no reset: the queue masks the read port while empty
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_ifq.sv
// Fetch-to-decode instruction queue with flush; head shows NOP/0 while empty.
module pipe_ifq import pipe_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = XLEN
) (
    input  logic       clock,
    input  logic       resetn,
    pipe_ifq_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 2 * WIDTH;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          d_flush_q;
    logic          in_ready_c;
    logic          out_valid_c;
    logic          push_c;
    logic          pop_c;
    logic [DW-1:0] rd_data;

    // in_ready looks only at occupancy, so a full queue refuses even while popping
    assign in_ready_c  = (count_q != CW'(DEPTH));
    assign out_valid_c = (count_q != '0);
    assign push_c      = bus.in_valid & in_ready_c & ~bus.f_flush;
    assign pop_c       = out_valid_c & bus.out_ready & ~bus.f_flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            d_flush_q <= 1'b0;
        end else begin
            d_flush_q <= bus.f_flush;
            if (bus.f_flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                // Pointers wrap naturally since DEPTH is a power of two
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
                case ({push_c, pop_c})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    ifq_regfile #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_regfile (
        .clock (clock),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata ({bus.in_pc4, bus.in_inst}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc4   = out_valid_c ? rd_data[DW-1:WIDTH] : '0;
    assign bus.out_inst  = out_valid_c ? rd_data[WIDTH-1:0] : WIDTH'(NOP_INST);
    assign bus.d_flush   = d_flush_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_ifq.sv
// Scoreboard bench for pipe_ifq: a plain queue model of expected contents is
// checked by a negedge monitor against every DUT output.
module tb_pipe_ifq;
    import pipe_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic clock;
    logic resetn;

    pipe_ifq_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    pipe_ifq #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    ifq_entry_t exp_q[$];
    logic       exp_dflush = 1'b0;
    bit         mon_en = 1'b0;
    int         mon_n;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs with the model each cycle, retires popped heads
    always @(negedge clock) begin
        if (mon_en) begin
            mon_n = exp_q.size();
            chk("count",     64'(bus.count),     64'(mon_n));
            chk("in_ready",  64'(bus.in_ready),  64'(mon_n != int'(DEPTH)));
            chk("out_valid", 64'(bus.out_valid), 64'(mon_n != 0));
            chk("d_flush",   64'(bus.d_flush),   64'(exp_dflush));
            if (mon_n != 0) begin
                chk("out_inst", 64'(bus.out_inst), 64'(exp_q[0].inst));
                chk("out_pc4",  64'(bus.out_pc4),  64'(exp_q[0].pc4));
                if (bus.out_ready) void'(exp_q.pop_front());
            end else begin
                chk("nop_inst", 64'(bus.out_inst), 64'(NOP_INST));
                chk("nop_pc4",  64'(bus.out_pc4),  64'd0);
            end
        end
    end

    // Drive one cycle and record what the model expects to be enqueued
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        logic acc;
        bus.in_valid  = v;
        bus.in_pc4    = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        bus.f_flush   = fl;
        acc = v && (exp_q.size() < int'(DEPTH)) && !fl;
        @(posedge clock);
        #1;
        exp_dflush = fl;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{pc4: pc, inst: inst});
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc4    = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;
        bus.f_flush   = 1'b0;

        #12;
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_d_flush",   64'(bus.d_flush),   64'd0);
        chk("rst_out_inst",  64'(bus.out_inst),  64'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // First push appears at the head one cycle later
        step(1'b1, 32'h4, 32'h2001_0005, 1'b0, 1'b0);
        chk("first_count", 64'(bus.count),    64'd1);
        chk("first_inst",  64'(bus.out_inst), 64'h2001_0005);
        chk("first_pc4",   64'(bus.out_pc4),  64'h4);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Fill past capacity, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        chk("full_count",    64'(bus.count),    64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_inst",  64'(bus.out_inst),  64'd0);

        // Steady push+pop at count 2 wraps pointers
        for (int i = 0; i < 2; i++) step(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b1, 1'b0);
        chk("pp_count", 64'(bus.count), 64'd2);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with simultaneous push and pop, then push right after
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h500, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_count",   64'(bus.count),     64'd0);
        chk("flush_valid",   64'(bus.out_valid), 64'd0);
        chk("flush_d_flush", 64'(bus.d_flush),   64'd1);
        step(1'b1, 32'h504, 32'h1234_5678, 1'b0, 1'b0);
        chk("post_flush_d_flush", 64'(bus.d_flush),  64'd0);
        chk("post_flush_count",   64'(bus.count),    64'd1);
        chk("post_flush_inst",    64'(bus.out_inst), 64'h1234_5678);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset mid-operation with three entries queued
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_pc4    = 32'h40;
        bus.in_inst   = 32'h8C22_0000;
        bus.out_ready = 1'b0;
        bus.f_flush   = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_count",    64'(bus.count),     64'd0);
        chk("arst_valid",    64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready),  64'd1);
        exp_q.delete();
        exp_dflush = 1'b0;
        #4;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        exp_q.push_back('{pc4: 32'h40, inst: 32'h8C22_0000});
        chk("post_rst_count", 64'(bus.count),    64'd1);
        chk("post_rst_inst",  64'(bus.out_inst), 64'h8C22_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ifq.md
PIPE_IFQ -- requirements
Module: pipe_ifq

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch-to-decode queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter WIDTH, default 32, width of the inst and pc4 fields.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  fetch stage presents an entry.
REQ-006 Port in_pc4  input  WIDTH  PC+4 of the presented instruction.
REQ-007 Port in_inst  input  WIDTH  presented instruction word.
REQ-008 Port in_ready  output  1  queue can accept an entry this cycle.
REQ-009 Port f_flush  input  1  squash request from the branch/jump resolution logic.
REQ-010 Port out_valid  output  1  head entry is valid for decode.
REQ-011 Port out_pc4  output  WIDTH  PC+4 of the head entry.
REQ-012 Port out_inst  output  WIDTH  instruction of the head entry.
REQ-013 Port out_ready  input  1  decode consumes the head entry (decode not stalled).
REQ-014 Port d_flush  output  1  registered flush indication to decode.
REQ-015 Port count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-016 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready, so a push is refused when full even if a pop occurs in the same cycle.
REQ-018 out_valid SHALL equal (count != 0); there is no bypass: an entry pushed in cycle N becomes visible at the head in cycle N+1.
REQ-019 When out_valid is 0, out_inst SHALL be 0 (NOP, sll $0,$0,0) and out_pc4 SHALL be 0.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL saturate neither above DEPTH nor below 0.
REQ-022 Entries SHALL leave the queue in push order.
REQ-023 When f_flush is 1 at a clock edge, both pointers and count SHALL clear to 0; any push or pop in that cycle SHALL be discarded; out_valid SHALL be 0 in the following cycle.
REQ-024 d_flush SHALL be f_flush delayed by exactly one clock.
REQ-025 A push in the cycle immediately after a flush SHALL be accepted normally.
REQ-026 out_ready while out_valid is 0 SHALL have no effect.

Reset
REQ-027 When resetn is 0, the pointers, count and d_flush SHALL clear to 0 asynchronously; out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-028 Storage contents SHALL NOT require reset; the outputs SHALL remain 0 through REQ-019.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries; the first edge after resetn deasserts SHALL accept a push.

Structure
REQ-030 The WIDTH default and the NOP encoding 32'h0 SHALL reside in the shared pipeline package pipe_pkg, together with a packed entry type {pc4, inst}.
REQ-031 The storage array SHALL be one sub-module, ifq_regfile: a DEPTH x (2*WIDTH) array with a synchronous write port and an asynchronous read port; pointer and count control SHALL stay in pipe_ifq.

Verification
REQ-032 Reset, then push inst 0x20010005/pc4 0x4 -> next cycle out_valid=1, out_inst=0x20010005, out_pc4=0x4, count=1.
REQ-033 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th push with in_valid=1 is refused; popping 4 entries returns them in push order, then out_valid=0 and out_inst=0.
REQ-034 With count=2, push and pop in the same cycle -> count stays 2; run 10 such cycles -> pointers wrap and the data order is preserved.
REQ-035 With count=3, assert f_flush together with a push and a pop -> next cycle count=0, out_valid=0, d_flush=1; one cycle later d_flush=0.
REQ-036 With count=3, pull resetn low between clock edges -> count=0 and out_valid=0 immediately; after release, a push of 0x8C220000 appears at the head one cycle later.
